// File: rtl/vga_scan_timing.sv
// Raster scan generator: X/Y counters, active-low syncs, blanking and line/frame strobes.
// Optional macro VGA_SCAN_FRAME_COUNT_EN adds a 16-bit frame_count output.
module vga_scan_timing #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    output logic [11:0] CounterX,
    output logic [11:0] CounterY,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_start,
`ifdef VGA_SCAN_FRAME_COUNT_EN
    output logic        frame_start,
    output logic [15:0] frame_count
`else
    output logic        frame_start
`endif
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS_W  = 12'(H_VIS);
    localparam logic [11:0] V_VIS_W  = 12'(V_VIS);
    localparam logic [11:0] HS_FIRST = 12'(H_VIS + H_FP);
    localparam logic [11:0] HS_LAST  = 12'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST = 12'(V_VIS + V_FP);
    localparam logic [11:0] VS_LAST  = 12'(V_VIS + V_FP + V_SYNC - 1);

    // Counters are 12 bits wide, so a larger raster cannot be represented.
    if ((H_TOTAL > 4096) || (V_TOTAL > 4096)) begin : g_size_check
        $error("vga_scan_timing: H_TOTAL and V_TOTAL must not exceed 4096");
    end

    function automatic logic in_window(input logic [11:0] pos,
                                       input logic [11:0] first,
                                       input logic [11:0] last);
        return (pos >= first) && (pos <= last);
    endfunction

    logic [11:0] x_r;
    logic [11:0] y_r;
    logic        hsync_r;
    logic        vsync_r;
    logic        video_on_r;
    logic        line_start_r;
    logic        frame_start_r;

    logic [11:0] x_nxt_s;
    logic [11:0] y_nxt_s;
    logic        line_wrap_s;
    logic        frame_wrap_s;

    // Next raster position and wrap events for the upcoming pixel.
    always_comb begin
        x_nxt_s      = x_r;
        y_nxt_s      = y_r;
        line_wrap_s  = 1'b0;
        frame_wrap_s = 1'b0;
        if (pix_en) begin
            if (x_r == H_LAST) begin
                x_nxt_s     = 12'd0;
                line_wrap_s = 1'b1;
                if (y_r == V_LAST) begin
                    y_nxt_s      = 12'd0;
                    frame_wrap_s = 1'b1;
                end else begin
                    y_nxt_s = y_r + 12'd1;
                end
            end else begin
                x_nxt_s = x_r + 12'd1;
            end
        end else begin
            x_nxt_s = x_r;
        end
    end

    // Decodes are taken from the next position so they align with the counters they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r           <= H_LAST;
            y_r           <= V_LAST;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            video_on_r    <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (pix_en) begin
            x_r           <= x_nxt_s;
            y_r           <= y_nxt_s;
            hsync_r       <= ~in_window(x_nxt_s, HS_FIRST, HS_LAST);
            vsync_r       <= ~in_window(y_nxt_s, VS_FIRST, VS_LAST);
            video_on_r    <= (x_nxt_s < H_VIS_W) && (y_nxt_s < V_VIS_W);
            line_start_r  <= line_wrap_s;
            frame_start_r <= frame_wrap_s;
        end else begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

`ifdef VGA_SCAN_FRAME_COUNT_EN
    logic [15:0] frame_count_r;

    // Frame counter steps on the same edge that raises frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_r <= 16'd0;
        end else if (frame_wrap_s) begin
            frame_count_r <= frame_count_r + 16'd1;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    assign frame_count = frame_count_r;
`endif

    assign CounterX    = x_r;
    assign CounterY    = y_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign video_on    = video_on_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Self-checking bench for vga_scan_timing on a reduced raster (100 x 60) so whole frames fit the run.
module tb_vga_scan_timing;

    localparam int H_VIS = 64, H_FP = 8, H_SYNC = 12, H_BP = 16;
    localparam int V_VIS = 40, V_FP = 4, V_SYNC = 3,  V_BP = 13;
    localparam int HT    = H_VIS + H_FP + H_SYNC + H_BP;   // 100
    localparam int VT    = V_VIS + V_FP + V_SYNC + V_BP;   // 60
    localparam int FRAME = HT * VT;                        // 6000

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [11:0] CounterX;
    logic [11:0] CounterY;
    logic        hsync, vsync, video_on, line_start, frame_start;
`ifdef VGA_SCAN_FRAME_COUNT_EN
    logic [15:0] frame_count;
    logic [15:0] m_fc;
`endif

    int vectors     = 0;
    int miscompares = 0;

    vga_scan_timing #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .CounterX   (CounterX),
        .CounterY   (CounterY),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .line_start (line_start),
`ifdef VGA_SCAN_FRAME_COUNT_EN
        .frame_start(frame_start),
        .frame_count(frame_count)
`else
        .frame_start(frame_start)
`endif
    );

    always #5 clk = ~clk;

    // Reference: the scan is just a linear pixel index inside the frame.
    int   m_p     = FRAME - 1;
    logic m_adv   = 1'b0;
    logic m_rst   = 1'b0;
    logic m_valid = 1'b0;
    logic force_req = 1'b0;
    logic toggle_on = 1'b0;

    always @(posedge clk) begin
        m_rst <= reset;
        if (reset) begin
            m_p     <= FRAME - 1;
            m_adv   <= 1'b0;
            m_valid <= 1'b1;
        end else if (pix_en) begin
            m_p   <= (m_p + 1) % FRAME;
            m_adv <= 1'b1;
        end else begin
            m_adv <= 1'b0;
        end
`ifdef VGA_SCAN_FRAME_COUNT_EN
        if (reset)
            m_fc <= 16'd0;
        else if (pix_en && ((m_p + 1) % FRAME == 0))
            m_fc <= m_fc + 16'd1;
        else if (force_req)
            m_fc <= 16'hFFFF;
        else
            m_fc <= m_fc;
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model plus period/width measurements.
    initial begin : compare
        int x, y;
        int hs_cnt = 0, fr_cnt = 0, vs_cnt = 0, lp_cnt = 0;
        bit hs_ok = 0, fr_ok = 0, lp_ok = 0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                x = m_p % HT;
                y = m_p / HT;
                chk("CounterX", 32'(CounterX), x);
                chk("CounterY", 32'(CounterY), y);
                chk("hsync", 32'(hsync), !((x >= H_VIS + H_FP) && (x < H_VIS + H_FP + H_SYNC)));
                chk("vsync", 32'(vsync), !((y >= V_VIS + V_FP) && (y < V_VIS + V_FP + V_SYNC)));
                chk("video_on", 32'(video_on), (x < H_VIS) && (y < V_VIS));
                chk("line_start", 32'(line_start), m_adv && (x == 0));
                chk("frame_start", 32'(frame_start), m_adv && (m_p == 0));
`ifdef VGA_SCAN_FRAME_COUNT_EN
                chk("frame_count", 32'(frame_count), 32'(m_fc));
`endif
                if (m_rst) begin
                    hs_ok = 0; fr_ok = 0; lp_ok = 0;
                end
                if (!toggle_on) lp_ok = 0;
                lp_cnt++;
                if (m_adv) fr_cnt++;
                if (m_adv && !hsync) hs_cnt++;
                if (m_adv && !vsync) vs_cnt++;
                if (line_start) begin
                    if (hs_ok) chk("hsync_width", hs_cnt, 12);
                    if (lp_ok) chk("line_period_toggle", lp_cnt, 200);
                    hs_cnt = 0; lp_cnt = 0;
                    hs_ok = 1;
                    lp_ok = toggle_on;
                end
                if (frame_start) begin
                    if (fr_ok) begin
                        chk("frame_period", fr_cnt, 6000);
                        chk("vsync_width", vs_cnt, 300);
                    end
                    fr_cnt = 0; vs_cnt = 0;
                    fr_ok = 1;
                end
            end
        end
    end

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        #2;
        reset  = r;
        pix_en = e;
    endtask

    initial begin : stim
        bit found;
        reset  = 1'b1;
        pix_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_x", 32'(CounterX), 99);
        chk("reset_y", 32'(CounterY), 59);
        chk("reset_video", 32'(video_on), 0);
        chk("reset_sync", 32'({hsync, vsync}), 3);
        chk("reset_strobes", 32'({line_start, frame_start}), 0);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("first_xy", 32'({CounterX, CounterY}), 0);
        chk("first_video", 32'(video_on), 1);
        chk("first_strobes", 32'({line_start, frame_start}), 3);
        chk("first_sync", 32'({hsync, vsync}), 3);
        @(negedge clk);
        chk("second_x", 32'(CounterX), 1);
        chk("second_strobes", 32'({line_start, frame_start}), 0);

        // Free run for two frames.
        repeat (2 * FRAME + 20) step(1'b0, 1'b1);

        // Half-rate enable pattern.
        toggle_on = 1'b1;
        for (int i = 0; i < 2 * FRAME + 400; i++) step(1'b0, i[0] ? 1'b0 : 1'b1);
        toggle_on = 1'b0;

        // Random enable with occasional resets.
        for (int i = 0; i < 9000; i++)
            step(($urandom_range(0, 699) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));

        // Directed reset when the presented position is (30,20).
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step(1'b0, 1'b1);
            if (m_p == 20 * HT + 29) found = 1;
        end
        chk("reach_30_20_timeout", 32'(found), 1);
        @(negedge clk);
        chk("pre_reset_pos", 32'({CounterX, CounterY}), {12'd30, 12'd20});
        #2;
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_pos", 32'({CounterX, CounterY}), {12'd99, 12'd59});
        chk("midreset_flags", 32'({video_on, hsync, vsync, line_start, frame_start}), 5'b01100);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("after_reset_pos", 32'({CounterX, CounterY}), 0);
        chk("after_reset_fs", 32'(frame_start), 1);

`ifdef VGA_SCAN_FRAME_COUNT_EN
        repeat (3 * FRAME) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        force dut.frame_count_r = 16'hFFFF;
        force_req = 1'b1;
        @(negedge clk);
        #2;
        release dut.frame_count_r;
        force_req = 1'b0;
        pix_en = 1'b1;
        found = 0;
        for (int i = 0; i < FRAME + 10 && !found; i++) begin
            @(negedge clk);
            if (m_adv && m_p == 0) found = 1;
        end
        chk("wrap_reached", 32'(found), 1);
        chk("frame_count_wrap", 32'(frame_count), 0);
`endif

        step(1'b0, 1'b0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
- Generates the raster scan counters (CounterX, CounterY), sync pulses and blanking for the synthesizer keyboard display.
- Directly upstream of the keyboard-bar decoders. CounterY drives the white-key row decode. CounterX and video_on drive the pixel colour mux.
- Default timing is 640x480 @ 60 Hz. The pixel rate comes from a clock-enable on the system clock.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pix_en  input  1  pixel clock-enable; scan advances one pixel per clk with pix_en=1
- CounterX  output  12  current horizontal position, 0..H_TOTAL-1
- CounterY  output  12  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- video_on  output  1  high when (CounterX,CounterY) is in the visible area
- line_start  output  1  one-clk strobe: CounterX just became 0
- frame_start  output  1  one-clk strobe: counters just became (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525). Both must be at most 4096; elaboration fails otherwise.
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk. reset has priority over pix_en.
- Reset values: CounterX = H_TOTAL-1, CounterY = V_TOTAL-1, hsync = 1, vsync = 1, video_on = 0, line_start = 0, frame_start = 0. This is the last pixel of the frame, so the first pix_en after reset presents (0,0).
- Advance (pix_en=1, no reset):
  - If CounterX = H_TOTAL-1: CounterX becomes 0. CounterY then increments, or wraps to 0 if it was V_TOTAL-1.
  - Otherwise CounterX increments and CounterY holds.
- Hold (pix_en=0): CounterX, CounterY, hsync, vsync and video_on hold. line_start and frame_start are 0.
- All outputs are registered and coherent. hsync, vsync, video_on and the strobes are computed from the next counter values, so on every clk they describe the CounterX/CounterY presented in the same cycle. There is zero latency between a counter value and its decode.
- Decode for the presented position:
  - hsync = 0 iff H_VIS+H_FP <= CounterX <= H_VIS+H_FP+H_SYNC-1 (656..751)
  - vsync = 0 iff V_VIS+V_FP <= CounterY <= V_VIS+V_FP+V_SYNC-1 (490..491)
  - video_on = 1 iff CounterX < H_VIS and CounterY < V_VIS
  - line_start = 1 for exactly the clk in which CounterX newly became 0 through an advance
  - frame_start = 1 for exactly the clk in which (CounterX,CounterY) newly became (0,0) through an advance
- Vertical sync uses the whole line, not per-pixel alignment: vsync changes only at the same time as CounterY.
- Reset mid-frame: on the next edge all outputs return to their reset values, regardless of pix_en. No strobe fires on the reset edge.
- Downstream contract: CounterY >= V_VIS never falls inside a key-bar row band, because 15 rows × 32 lines = 480.

Optional Feature:
- Macro: VGA_SCAN_FRAME_COUNT_EN.
- Defined: adds output port frame_count (16 bits).
  - Reset value 0.
  - Increments by 1 on the same edge that asserts frame_start.
  - Wraps from 65535 to 0.
  - Holds when pix_en=0.
  - Used to time the key-press highlight fade.
- Undefined: the port and its counter do not exist. All other behaviour is identical.

Test Plan:
- Reset released, then pix_en=1 continuously -> first clk: CounterX=0, CounterY=0, video_on=1, frame_start=1, line_start=1, hsync=1, vsync=1. Next clk: CounterX=1, both strobes 0.
- Free-run one line -> video_on falls when CounterX=640. hsync=0 for CounterX 656..751, exactly 96 clks. CounterX 799 is followed by CounterX=0, CounterY=1, line_start=1.
- Free-run a full frame -> vsync=0 for CounterY 490..491, exactly 1600 pix_en clks. frame_start asserts again after exactly 420000 pix_en clks. (799,524) is followed by (0,0).
- pix_en toggles 1,0,1,0 (50 MHz to 25 MHz pattern) -> counters advance only on enabled clks. Strobes last one clk only, never during pix_en=0 cycles. Line period = 1600 clks.
- reset pulsed for 1 clk at (300,200) with pix_en=1 -> next clk shows (799,524), video_on=0, hsync=1, vsync=1, no strobes. The following enabled clk shows (0,0) with frame_start=1.
- With VGA_SCAN_FRAME_COUNT_EN defined: run 3 frames -> frame_count = 0,1,2,3 at successive frame_start edges. Force the count to 65535, then advance one frame -> frame_count wraps to 0.
